// File: rtl/led_scan_driver_p_pkg.sv
// Shared types and width helpers for the LED matrix scan driver.
// Pure declarations; no logic, no timing.
package led_pkg;

  localparam int DEF_CH_BITS = 3;

  localparam logic [1:0] ROLL_HOLD = 2'b00;
  localparam logic [1:0] ROLL_INC  = 2'b01;
  localparam logic [1:0] ROLL_DEC  = 2'b10;

  typedef enum logic [1:0] {FETCH, BLANK, SHOW} scan_state_t;

  typedef struct packed {
    logic [DEF_CH_BITS-1:0] r;
    logic [DEF_CH_BITS-1:0] g;
    logic [DEF_CH_BITS-1:0] b;
  } rgb_pix_t;

  // Bits needed to index n items; never narrower than one bit.
  function automatic int width_of(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/led_scan_driver_p_if.sv
// Frame buffer read port: 1-cycle read latency, data valid the clock after rd_en.
// No backpressure; the RAM must answer every strobe.
interface led_scan_driver_p_if #(
  parameter int ADDR_W = 6,
  parameter int PIX_W  = 9
);
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [PIX_W-1:0]  rd_data;

  modport master (output rd_en, output rd_addr, input rd_data);
  modport slave  (input rd_en, input rd_addr, output rd_data);
endinterface

// File: rtl/led_scan_driver_p_pwm_col.sv
// Combinational PWM column compare for one colour, active-low outputs.
// Zero latency; no flow control.
module led_pwm_col
  import led_pkg::*;
#(
  parameter int COLS    = 8,
  parameter int CH_BITS = DEF_CH_BITS
) (
  input  logic [COLS-1:0][CH_BITS-1:0] chan,
  input  logic [CH_BITS-1:0]           pwm_cnt,
  input  logic [1:0]                   bright_level,
  output logic [COLS-1:0]              col
);

  always_comb begin
    col = '1;
    for (int c = 0; c < COLS; c++) begin
      col[c] = ~((chan[c] >> bright_level) > pwm_cnt);
    end
  end

endmodule

// File: rtl/led_scan_driver_p.sv
// ROWS x COLS RGB matrix scanner: fetch line, blank, PWM show; scroll + brightness.
// Pins registered (1-cycle lag after each state edge); LED_SCAN_SYNC_CTRL_EN latches controls per frame.
module led_scan_driver_p
  import led_pkg::*;
#(
  parameter int ROWS      = 8,
  parameter int COLS      = 8,
  parameter int CH_BITS   = DEF_CH_BITS,
  parameter int PWM_DIV   = 4,
  parameter int BLANK_CYC = 2,
  parameter int ROLL_DIV  = 4096
) (
  input  logic                     clk,
  input  logic                     rst_n,
  led_scan_driver_p_if.master      fb,
  input  logic [1:0]               roll_h,
  input  logic [1:0]               roll_v,
  input  logic [1:0]               bright_level,
  output logic [ROWS-1:0]          row_sel,
  output logic [COLS-1:0]          col_r,
  output logic [COLS-1:0]          col_g,
  output logic [COLS-1:0]          col_b,
  output logic [$clog2(ROWS)-1:0]  cur_row,
  output logic                     frame_start
);

  localparam int ADDR_W   = width_of(ROWS * COLS);
  localparam int ROW_W    = width_of(ROWS);
  localparam int COL_W    = width_of(COLS);
  localparam int SHOW_CYC = (1 << CH_BITS) * PWM_DIV;
  localparam int CNT_W    = width_of(max3(COLS, BLANK_CYC, SHOW_CYC) + 1);
  localparam int FC_W     = width_of(ROLL_DIV);
  localparam int PD_W     = width_of(PWM_DIV);

  typedef struct packed {
    logic [CH_BITS-1:0] r;
    logic [CH_BITS-1:0] g;
    logic [CH_BITS-1:0] b;
  } pix_t;

  scan_state_t        state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               row_done, fetch_rd, blank_last, frame_end;
  logic [ROW_W-1:0]   row_q, v_off, v_step, row_idx;
  logic [COL_W-1:0]   h_off, h_step, col_idx, rd_idx, cap_idx;
  logic [ROW_W:0]     row_sum;
  logic [COL_W:0]     col_sum;
  logic [ADDR_W-1:0]  rd_addr_q, addr;
  logic               rd_en_q, cap_vld;
  logic [FC_W-1:0]    frame_cnt;
  logic [CH_BITS-1:0] pwm_cnt;
  logic [PD_W-1:0]    pwm_pre;
  logic [1:0]         bright_s, roll_h_s, roll_v_s;
  logic               h_act, v_act;
  pix_t               line_buf [COLS];
  pix_t               line_nxt [COLS];
  pix_t               disp     [COLS];
  logic [COLS-1:0][CH_BITS-1:0] chan_r, chan_g, chan_b;
  logic [COLS-1:0]    pwm_r, pwm_g, pwm_b;

`ifdef LED_SCAN_SYNC_CTRL_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bright_s <= '0;
      roll_h_s <= ROLL_HOLD;
      roll_v_s <= ROLL_HOLD;
    end else if (frame_start) begin
      bright_s <= bright_level;
      roll_h_s <= roll_h;
      roll_v_s <= roll_v;
    end
  end
`else
  assign bright_s = bright_level;
  assign roll_h_s = roll_h;
  assign roll_v_s = roll_v;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FETCH;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // FETCH has one spare cycle so the final read is issued before BLANK.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt + 1'b1;
    row_done   = 1'b0;
    fetch_rd   = 1'b0;
    blank_last = 1'b0;
    unique case (state)
      FETCH: begin
        fetch_rd = (cnt < CNT_W'(COLS));
        if (cnt == CNT_W'(COLS)) begin
          state_nxt = BLANK;
          cnt_nxt   = '0;
        end
      end
      BLANK: begin
        if (cnt == CNT_W'(BLANK_CYC - 1)) begin
          blank_last = 1'b1;
          state_nxt  = SHOW;
          cnt_nxt    = '0;
        end
      end
      SHOW: begin
        if (cnt == CNT_W'(SHOW_CYC - 1)) begin
          row_done  = 1'b1;
          state_nxt = FETCH;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = FETCH;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    row_sum = {1'b0, row_q} + {1'b0, v_off};
    if (row_sum >= (ROW_W+1)'(ROWS)) row_sum = row_sum - (ROW_W+1)'(ROWS);
    col_sum = {1'b0, COL_W'(cnt)} + {1'b0, h_off};
    if (col_sum >= (COL_W+1)'(COLS)) col_sum = col_sum - (COL_W+1)'(COLS);
    row_idx = row_sum[ROW_W-1:0];
    col_idx = col_sum[COL_W-1:0];
    addr    = ADDR_W'(row_idx) * ADDR_W'(COLS) + ADDR_W'(col_idx);
  end

  assign frame_end = row_done && (row_q == ROW_W'(ROWS - 1));
  assign h_act     = (roll_h_s == ROLL_INC) || (roll_h_s == ROLL_DEC);
  assign v_act     = (roll_v_s == ROLL_INC) || (roll_v_s == ROLL_DEC);

  always_comb begin
    h_step = h_off;
    v_step = v_off;
    if (roll_h_s == ROLL_INC)      h_step = (h_off == COL_W'(COLS - 1)) ? '0 : h_off + 1'b1;
    else if (roll_h_s == ROLL_DEC) h_step = (h_off == '0) ? COL_W'(COLS - 1) : h_off - 1'b1;
    if (roll_v_s == ROLL_INC)      v_step = (v_off == ROW_W'(ROWS - 1)) ? '0 : v_off + 1'b1;
    else if (roll_v_s == ROLL_DEC) v_step = (v_off == '0) ? ROW_W'(ROWS - 1) : v_off - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q     <= '0;
      h_off     <= '0;
      v_off     <= '0;
      frame_cnt <= '0;
    end else begin
      if (row_done) row_q <= frame_end ? '0 : row_q + 1'b1;
      if (frame_end && (h_act || v_act)) begin
        if (frame_cnt == FC_W'(ROLL_DIV - 1)) begin
          frame_cnt <= '0;
          h_off     <= h_step;
          v_off     <= v_step;
        end else begin
          frame_cnt <= frame_cnt + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_pre <= '0;
      pwm_cnt <= '0;
    end else if (state != SHOW) begin
      pwm_pre <= '0;
      pwm_cnt <= '0;
    end else if (pwm_pre == PD_W'(PWM_DIV - 1)) begin
      pwm_pre <= '0;
      pwm_cnt <= pwm_cnt + 1'b1;
    end else begin
      pwm_pre <= pwm_pre + 1'b1;
    end
  end

  // cap_vld/cap_idx trail rd_en by one clock, lining up with rd_data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_en_q     <= 1'b0;
      rd_addr_q   <= '0;
      rd_idx      <= '0;
      cap_vld     <= 1'b0;
      cap_idx     <= '0;
      frame_start <= 1'b0;
      row_sel     <= '0;
      col_r       <= '1;
      col_g       <= '1;
      col_b       <= '1;
    end else begin
      rd_en_q <= fetch_rd;
      if (fetch_rd) begin
        rd_addr_q <= addr;
        rd_idx    <= COL_W'(cnt);
      end
      cap_vld     <= rd_en_q;
      cap_idx     <= rd_idx;
      frame_start <= (state == FETCH) && (cnt == '0) && (row_q == '0);
      row_sel     <= (state == SHOW) ? (ROWS'(1) << row_q) : '0;
      col_r       <= (state == SHOW) ? pwm_r : '1;
      col_g       <= (state == SHOW) ? pwm_g : '1;
      col_b       <= (state == SHOW) ? pwm_b : '1;
    end
  end

  // Forwarding the in-flight capture keeps BLANK_CYC=1 correct.
  always_comb begin
    line_nxt = line_buf;
    if (cap_vld) line_nxt[cap_idx] = pix_t'(fb.rd_data);
  end

  always_ff @(posedge clk) begin
    line_buf <= line_nxt;
    if (blank_last) disp <= line_nxt;
  end

  always_comb begin
    chan_r = '0;
    chan_g = '0;
    chan_b = '0;
    for (int c = 0; c < COLS; c++) begin
      chan_r[c] = disp[c].r;
      chan_g[c] = disp[c].g;
      chan_b[c] = disp[c].b;
    end
  end

  led_pwm_col #(.COLS(COLS), .CH_BITS(CH_BITS)) u_pwm_r (
    .chan(chan_r), .pwm_cnt(pwm_cnt), .bright_level(bright_s), .col(pwm_r));
  led_pwm_col #(.COLS(COLS), .CH_BITS(CH_BITS)) u_pwm_g (
    .chan(chan_g), .pwm_cnt(pwm_cnt), .bright_level(bright_s), .col(pwm_g));
  led_pwm_col #(.COLS(COLS), .CH_BITS(CH_BITS)) u_pwm_b (
    .chan(chan_b), .pwm_cnt(pwm_cnt), .bright_level(bright_s), .col(pwm_b));

  assign fb.rd_en   = rd_en_q;
  assign fb.rd_addr = rd_addr_q;
  assign cur_row    = row_q;

endmodule

// File: tb/tb_led_scan_driver_p.sv
// Scoreboard bench for led_scan_driver_p: 8x8, PWM_DIV=1, BLANK_CYC=2, ROLL_DIV=2.
module tb_led_scan_driver_p;
  import led_pkg::*;

  localparam int ROWS = 8, COLS = 8, CH_BITS = 3, PWM_DIV = 1, BLANK_CYC = 2, ROLL_DIV = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] roll_h, roll_v, bright_level;
  logic [ROWS-1:0] row_sel;
  logic [COLS-1:0] col_r, col_g, col_b;
  logic [2:0] cur_row;
  logic       frame_start;

  always #5 clk = ~clk;

  led_scan_driver_p_if #(.ADDR_W(6), .PIX_W(9)) fb ();

  led_scan_driver_p #(
    .ROWS(ROWS), .COLS(COLS), .CH_BITS(CH_BITS), .PWM_DIV(PWM_DIV),
    .BLANK_CYC(BLANK_CYC), .ROLL_DIV(ROLL_DIV)
  ) dut (
    .clk(clk), .rst_n(rst_n), .fb(fb), .roll_h(roll_h), .roll_v(roll_v),
    .bright_level(bright_level), .row_sel(row_sel), .col_r(col_r), .col_g(col_g),
    .col_b(col_b), .cur_row(cur_row), .frame_start(frame_start)
  );

  rgb_pix_t mem [ROWS*COLS];

  always @(posedge clk) fb.rd_data <= fb.rd_en ? mem[fb.rd_addr] : 9'($urandom);

  typedef struct packed { logic [5:0] addr; logic fs; } rd_exp_t;
  typedef struct packed { logic [7:0] row; logic [7:0] r; logic [7:0] g; logic [7:0] b; } show_exp_t;

  rd_exp_t   rd_q[$];
  show_exp_t show_q[$];
  int errs = 0, checks = 0;
  int h_m = 0, v_m = 0, fc_m = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pix_addr(input int r, input int c);
    return ((r + v_m) % ROWS) * COLS + ((c + h_m) % COLS);
  endfunction

  task automatic push_reads();
    rd_exp_t e;
    for (int r = 0; r < ROWS; r++)
      for (int k = 0; k < COLS; k++) begin
        e.addr = 6'(pix_addr(r, k));
        e.fs   = (r == 0 && k == 0);
        rd_q.push_back(e);
      end
  endtask

  // A channel lights in slot s when s < (value / 2^bright).
  function automatic logic lit(input logic [2:0] val, input logic [1:0] br, input int s);
    int thr;
    thr = int'(val) / (1 << br);
    return s < thr;
  endfunction

  task automatic push_show(input logic [1:0] br);
    show_exp_t e;
    rgb_pix_t  p;
    for (int r = 0; r < ROWS; r++)
      for (int s = 0; s < (1 << CH_BITS); s++)
        for (int d = 0; d < PWM_DIV; d++) begin
          e.row = 8'(1 << r);
          e.r = '1; e.g = '1; e.b = '1;
          for (int c = 0; c < COLS; c++) begin
            p = mem[pix_addr(r, c)];
            e.r[c] = !lit(p.r, br, s);
            e.g[c] = !lit(p.g, br, s);
            e.b[c] = !lit(p.b, br, s);
          end
          show_q.push_back(e);
        end
  endtask

  task automatic model_frame_end(input logic [1:0] rh, input logic [1:0] rv);
    bit ha, va;
    ha = (rh == 2'b01) || (rh == 2'b10);
    va = (rv == 2'b01) || (rv == 2'b10);
    if (ha || va) begin
      if (fc_m == ROLL_DIV - 1) begin
        fc_m = 0;
        if (rh == 2'b01) h_m = (h_m + 1) % COLS;
        else if (rh == 2'b10) h_m = (h_m + COLS - 1) % COLS;
        if (rv == 2'b01) v_m = (v_m + 1) % ROWS;
        else if (rv == 2'b10) v_m = (v_m + ROWS - 1) % ROWS;
      end else begin
        fc_m++;
      end
    end
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_rd_en"}, fb.rd_en, 0);
    chk({tag, "_rd_addr"}, fb.rd_addr, 0);
    chk({tag, "_row_sel"}, row_sel, 0);
    chk({tag, "_cols"}, {col_r, col_g, col_b}, 24'hFFFFFF);
    chk({tag, "_cur_row"}, cur_row, 0);
    chk({tag, "_frame_start"}, frame_start, 0);
  endtask

  task automatic wait_fs();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk); #1;
      if (frame_start) break;
    end
    chk("frame_start_seen", frame_start, 1);
  endtask

  task automatic run_frame(input logic [1:0] br, input logic [1:0] rh, input logic [1:0] rv);
    wait_fs();
    chk("rd_pending", rd_q.size(), 63);
    chk("show_drain", show_q.size(), 0);
    chk("cur_row_fs", cur_row, 0);
    bright_level = br;
    roll_h       = rh;
    roll_v       = rv;
    push_show(br);
    model_frame_end(rh, rv);
    push_reads();
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (fb.rd_en) begin
        if (rd_q.size() == 0) chk("rd_unexpected", fb.rd_en, 0);
        else begin
          rd_exp_t e;
          e = rd_q.pop_front();
          chk("rd_addr", fb.rd_addr, e.addr);
          chk("frame_start", frame_start, e.fs);
        end
      end else begin
        chk("frame_start_idle", frame_start, 0);
      end
      if (row_sel != '0) begin
        if (show_q.size() == 0) chk("show_unexpected", row_sel, 0);
        else begin
          show_exp_t s;
          s = show_q.pop_front();
          chk("row_sel", row_sel, s.row);
          chk("col_r", col_r, s.r);
          chk("col_g", col_g, s.g);
          chk("col_b", col_b, s.b);
        end
      end else begin
        chk("cols_blank", {col_r, col_g, col_b}, 24'hFFFFFF);
      end
    end
  end

  localparam int NF = 14;
  logic [1:0] br_tab [NF] = '{2'd0, 2'd2, 2'd3, 2'd1, 2'd0, 2'd1, 2'd2, 2'd0, 2'd3, 2'd0, 2'd1, 2'd2, 2'd0, 2'd0};
  logic [1:0] rh_tab [NF] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd0, 2'd3, 2'd0, 2'd0, 2'd0};
  logic [1:0] rv_tab [NF] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd0, 2'd3, 2'd0, 2'd0, 2'd0};

  initial begin
    rst_n        = 1'b0;
    roll_h       = 2'b00;
    roll_v       = 2'b00;
    bright_level = 2'b00;
    for (int i = 0; i < ROWS * COLS; i++) mem[i] = rgb_pix_t'($urandom);
    mem[3]  = '{r: 3'd7, g: 3'd0, b: 3'd0};
    mem[5]  = '{r: 3'd7, g: 3'd7, b: 3'd7};
    mem[10] = '0;
    mem[20] = '0;
    #12;
    reset_checks("reset");
    push_reads();
    @(negedge clk);
    rst_n = 1'b1;

    for (int f = 0; f < NF; f++) run_frame(br_tab[f], rh_tab[f], rv_tab[f]);

    for (int i = 0; i < 400; i++) begin
      @(negedge clk); #1;
      if (row_sel == 8'h20) break;
    end
    chk("row5_reached", row_sel, 8'h20);
    #2;
    rst_n = 1'b0;
    #1;
    reset_checks("mid_reset");
    rd_q.delete();
    show_q.delete();
    h_m = 0; v_m = 0; fc_m = 0;
    roll_h = 2'b00; roll_v = 2'b00; bright_level = 2'b00;
    push_reads();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    run_frame(2'd1, 2'd0, 2'd0);
    run_frame(2'd0, 2'd0, 2'd0);
    wait_fs();
    chk("final_show_drain", show_q.size(), 0);
    chk("final_rd_pending", rd_q.size(), 63);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/led_scan_driver_p.md
Name: led_scan_driver_p

Overview:
- Parametrised successor to the fixed 8x8 LED matrix scan driver.
- Scans a ROWS x COLS RGB matrix row by row. For each row it fetches pixels from the frame buffer through a 1-cycle-latency read port into a line buffer, blanks the outputs, then drives PWM column data.
- Supports horizontal and vertical scrolling, with independently selectable direction per axis.
- Supports 4-level global brightness.
- Sits between the frame buffer RAM and the matrix pins.

Parameters:
- ROWS, 8, number of matrix rows (>=2).
- COLS, 8, number of matrix columns (>=2).
- CH_BITS, 3, intensity bits per colour channel. Pixel width PIX_W = 3*CH_BITS, packed {R,G,B}.
- PWM_DIV, 4, clocks per PWM slot (>=1).
- BLANK_CYC, 2, anti-ghost blanking clocks before each row is shown (>=1).
- ROLL_DIV, 4096, frames per scroll step (>=1).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- rd_en  out  1  frame buffer read strobe.
- rd_addr  out  ADDR_W  read address; ADDR_W = $clog2(ROWS*COLS).
- rd_data  in  PIX_W  pixel data, valid exactly 1 clock after rd_en.
- roll_h  in  2  horizontal scroll: 00/11 hold, 01 h_off+1, 10 h_off-1.
- roll_v  in  2  vertical scroll: 00/11 hold, 01 v_off+1, 10 v_off-1.
- bright_level  in  2  00 full, 01 1/2, 10 1/4, 11 1/8.
- row_sel  out  ROWS  one-hot row drive, active-high.
- col_r, col_g, col_b  out  COLS  column drive, active-low.
- cur_row  out  $clog2(ROWS)  logical row currently being scanned.
- frame_start  out  1  1-clock pulse on entering FETCH for row 0.

Behaviour:
- Reset values: row_sel=0, col_*=all 1, rd_en=0, rd_addr=0, cur_row=0, frame_start=0, h_off=v_off=0, frame counter=0, state=FETCH.
- FETCH (COLS+1 clocks):
  - Cycles k=0..COLS-1: rd_en=1, rd_addr = ((cur_row+v_off) mod ROWS)*COLS + ((k+h_off) mod COLS).
  - The read issued at cycle k is captured into line_buf[k] at cycle k+1.
  - Outputs are blanked throughout FETCH.
- BLANK (BLANK_CYC clocks):
  - row_sel=0, col_*=all 1.
  - On the last cycle, line_buf is copied into the display registers.
- SHOW (2^CH_BITS * PWM_DIV clocks):
  - pwm_cnt counts 0..2^CH_BITS-1, advancing every PWM_DIV clocks.
  - row_sel = one-hot(cur_row).
  - col_x[c] = ~((chan_x[c] >> bright_level) > pwm_cnt); comparison is CH_BITS wide and the shift zero-fills.
  - Channel value 0 is always off; the maximum value at full brightness is on for 2^CH_BITS-1 slots.
- End of SHOW:
  - cur_row advances; wrap ROWS-1 -> 0 is a frame end.
  - Next state is FETCH.
- Output timing: row_sel and col_* are registered. They change on the clock edge after the state transition, so every state edge has 1-cycle output latency.
- Frame end:
  - If roll_h or roll_v is active (01 or 10), the frame counter increments.
  - On reaching ROLL_DIV-1, the counter clears and each axis steps its offset by +/-1.
  - Offset arithmetic is modulo COLS/ROWS: 0-1 wraps to max, max+1 wraps to 0.
  - If both axes are at hold, the frame counter is held; offsets are never auto-cleared.
- bright_level and roll_* are used combinationally each clock unless the optional feature below is enabled.
- Reset mid-row forces the reset values immediately and restarts at FETCH, row 0.
- rd_data is ignored except in the capture cycles.

Optional Feature:
- Macro: LED_SCAN_SYNC_CTRL_EN.
- Defined: bright_level, roll_h and roll_v are sampled into shadow registers only in the frame_start cycle, so no change occurs mid-frame.
- Undefined: inputs are used live, as described under Behaviour.

Decomposition:
- Shared package led_pkg:
  - Function clog2-based width helpers.
  - Typedef rgb_pix_t (packed r/g/b, CH_BITS each).
  - Enum scan_state_t {FETCH, BLANK, SHOW}.
  - Roll encodings ROLL_HOLD/ROLL_INC/ROLL_DEC.
- One natural sub-module: led_pwm_col. It is combinational, takes the display registers, pwm_cnt and bright_level, and produces the active-low column vectors; instantiate it once per colour.

Test Plan (ROWS=COLS=8, CH_BITS=3, PWM_DIV=1, BLANK_CYC=2, ROLL_DIV=2; row period 19 clocks, frame 152):
- Reset release -> rd_en high 8 clocks with addresses 0..7, frame_start pulse on the first; row_sel=0 until SHOW; row_sel=8'h01 for 8 clocks.
- Pixel R=7 at (0,3), bright 00 -> col_r[3]=0 for 7 slots and 1 for slot 7; with bright 10 (threshold 1) -> low for slot 0 only.
- Pixel values 0 and bright 11 with value 7 (threshold 0) -> column stays all 1 during SHOW.
- roll_h=01 for 2 frames -> third frame row 0 addresses 1,2,...,7,0; roll_h=10 from h_off=0 -> h_off=7, first address 7.
- roll_v=01 and roll_h=10 stepped together -> row 0 fetch addresses (1*8)+((k+7) mod 8); roll 00 afterwards -> offsets held over 4 frames.
- Assert rst_n low mid-SHOW of row 5 -> outputs return to reset values asynchronously; after release, scan restarts at row 0 and offsets are 0.
